// File: rtl/traffic_ctrl_n_if.sv
// Lamp/sensor bundle between the traffic controller and its environment.
interface traffic_ctrl_n_if #(
   parameter int unsigned NUM_DIR = 2
);
   localparam int unsigned PW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

   logic               FM;
   logic               TEST;
   logic [NUM_DIR-1:0] REQ;
   logic [NUM_DIR-1:0] GRN;
   logic [NUM_DIR-1:0] YLW;
   logic [NUM_DIR-1:0] RED;
   logic [PW-1:0]      PHASE;
   logic [1:0]         STATE;

   modport master (output FM, TEST, REQ, input GRN, YLW, RED, PHASE, STATE);
   modport slave  (input FM, TEST, REQ, output GRN, YLW, RED, PHASE, STATE);
endinterface

// File: rtl/traffic_ctrl_n.sv
// N-direction traffic-light controller: demand-driven round-robin right-of-way
// with programmable green/yellow/all-red timing, prescaled ticks and flash mode.
module traffic_ctrl_n #(
   parameter int unsigned NUM_DIR  = 2,
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned GRN_T    = 8,
   parameter int unsigned YLW_T    = 3,
   parameter int unsigned ARED_T   = 2
) (
   input  logic            CK,
   input  logic            CLRN,
   traffic_ctrl_n_if.slave bus
);

   localparam int unsigned PW   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;
   localparam int unsigned TMAX = (GRN_T >= YLW_T && GRN_T >= ARED_T) ? GRN_T :
                                  ((YLW_T >= ARED_T) ? YLW_T : ARED_T);
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned SW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      ST_ARED   = 2'b00,
      ST_GREEN  = 2'b01,
      ST_YELLOW = 2'b10,
      ST_FLASH  = 2'b11
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [TW-1:0]      r_timer, w_timer_nxt;
   logic [PW-1:0]      r_ptr, w_ptr_nxt, w_nxt_dir, w_cand;
   logic               r_flash, w_flash_nxt;
   logic [SW-1:0]      r_pre;
   logic               w_tick, w_found, w_other_req;
   logic [NUM_DIR-1:0] w_ptr_oh, w_nxt_oh;
   logic [NUM_DIR-1:0] w_grn_nxt, w_ylw_nxt, w_red_nxt;
   logic [NUM_DIR-1:0] r_grn, r_ylw, r_red;

   // Tick prescaler; held at 0 in TEST so it restarts cleanly when TEST drops.
   assign w_tick = bus.TEST | (r_pre == SW'(PRESCALE - 1));

   always_ff @(posedge CK or negedge CLRN) begin
      if (!CLRN)                          r_pre <= '0;
      else if (bus.TEST)                  r_pre <= '0;
      else if (r_pre == SW'(PRESCALE - 1)) r_pre <= '0;
      else                                r_pre <= r_pre + SW'(1);
   end

   assign w_ptr_oh    = NUM_DIR'(1) << r_ptr;
   assign w_other_req = |(bus.REQ & ~w_ptr_oh);

   // Round-robin search starting after PTR; candidates are always < NUM_DIR.
   always_comb begin
      w_found   = 1'b0;
      w_cand    = '0;
      w_nxt_dir = PW'((32'(r_ptr) + 32'd1) % NUM_DIR);
      for (int unsigned k = 1; k <= NUM_DIR; k++) begin
         w_cand = PW'((32'(r_ptr) + k) % NUM_DIR);
         if (!w_found && bus.REQ[w_cand]) begin
            w_found   = 1'b1;
            w_nxt_dir = w_cand;
         end
      end
   end

   // State register plus lamps registered from the next-state decode.
   always_ff @(posedge CK or negedge CLRN) begin
      if (!CLRN) begin
         r_state <= ST_ARED;
         r_timer <= TW'(ARED_T - 1);
         r_ptr   <= PW'(NUM_DIR - 1);
         r_flash <= 1'b1;
         r_grn   <= '0;
         r_ylw   <= '0;
         r_red   <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_ptr   <= w_ptr_nxt;
         r_flash <= w_flash_nxt;
         r_grn   <= w_grn_nxt;
         r_ylw   <= w_ylw_nxt;
         r_red   <= w_red_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_ptr_nxt   = r_ptr;
      w_flash_nxt = r_flash;
      if (w_tick) begin
         case (r_state)
            ST_ARED: begin
               if (r_timer != '0) begin
                  w_timer_nxt = r_timer - TW'(1);
               end else if (bus.FM) begin
                  w_state_nxt = ST_FLASH;
                  w_flash_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_GREEN;
                  w_ptr_nxt   = w_nxt_dir;
                  w_timer_nxt = TW'(GRN_T - 1);
               end
            end
            ST_GREEN: begin
               if (r_timer != '0) begin
                  w_timer_nxt = r_timer - TW'(1);
               end else if (bus.FM || w_other_req) begin
                  w_state_nxt = ST_YELLOW;
                  w_timer_nxt = TW'(YLW_T - 1);
               end
            end
            ST_YELLOW: begin
               if (r_timer != '0) begin
                  w_timer_nxt = r_timer - TW'(1);
               end else begin
                  w_state_nxt = ST_ARED;
                  w_timer_nxt = TW'(ARED_T - 1);
               end
            end
            default: begin
               if (!bus.FM) begin
                  w_state_nxt = ST_ARED;
                  w_timer_nxt = TW'(ARED_T - 1);
               end else begin
                  w_flash_nxt = ~r_flash;
               end
            end
         endcase
      end
   end

   // Lamp decode of the next state.
   assign w_nxt_oh = NUM_DIR'(1) << w_ptr_nxt;

   always_comb begin
      w_grn_nxt = '0;
      w_ylw_nxt = '0;
      w_red_nxt = '1;
      case (w_state_nxt)
         ST_GREEN: begin
            w_grn_nxt = w_nxt_oh;
            w_red_nxt = ~w_nxt_oh;
         end
         ST_YELLOW: begin
            w_ylw_nxt = w_nxt_oh;
            w_red_nxt = ~w_nxt_oh;
         end
         ST_FLASH: begin
            w_ylw_nxt = {NUM_DIR{w_flash_nxt}};
            w_red_nxt = '0;
         end
         default: ;
      endcase
   end

   assign bus.GRN   = r_grn;
   assign bus.YLW   = r_ylw;
   assign bus.RED   = r_red;
   assign bus.PHASE = r_ptr;
   assign bus.STATE = r_state;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed and randomized checks of traffic_ctrl_n for 2, 3 and 4 directions.
module tb_traffic_ctrl_n;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   traffic_ctrl_n_if #(.NUM_DIR(2)) if2 ();
   traffic_ctrl_n_if #(.NUM_DIR(4)) if4 ();
   traffic_ctrl_n_if #(.NUM_DIR(3)) if3 ();

   traffic_ctrl_n #(.NUM_DIR(2)) d2 (.CK(clk), .CLRN(rst_n), .bus(if2.slave));
   traffic_ctrl_n #(.NUM_DIR(4)) d4 (.CK(clk), .CLRN(rst_n), .bus(if4.slave));
   traffic_ctrl_n #(.NUM_DIR(3)) d3 (.CK(clk), .CLRN(rst_n), .bus(if3.slave));

   // Hold reset two cycles, release on a falling edge; next rising edge is edge 1.
   task automatic start();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.PHASE, if2.GRN, if2.YLW, if2.RED} !== {2'b00, 1'b1, 2'b00, 2'b00, 2'b11}) begin
         n_bad++;
         $display("FAIL reset2: got st=%b ph=%b g=%b y=%b r=%b want st=00 ph=1 g=00 y=00 r=11",
                  if2.STATE, if2.PHASE, if2.GRN, if2.YLW, if2.RED);
      end
      n_vec++;
      if ({if4.STATE, if4.PHASE, if4.GRN, if4.YLW, if4.RED} !== {2'b00, 2'd3, 4'h0, 4'h0, 4'hf}) begin
         n_bad++;
         $display("FAIL reset4: got st=%b ph=%0d g=%b y=%b r=%b want st=00 ph=3 g=0000 y=0000 r=1111",
                  if4.STATE, if4.PHASE, if4.GRN, if4.YLW, if4.RED);
      end
   endtask

   // Full rotation at one tick per cycle: ARED to edge 1, then 8 G / 3 Y / 2 A per direction.
   task automatic test_test_mode();
      logic [1:0] st, g, y, r;
      logic       ph;
      int         t;
      if2.TEST = 1'b1; if2.REQ = 2'b11; if2.FM = 1'b0;
      start();
      for (int e = 1; e <= 28; e++) begin
         @(negedge clk);
         if (e == 1) begin
            st = 2'b00; ph = 1'b1;
         end else begin
            t  = e - 2;
            ph = 1'((t / 13) % 2);
            st = (t % 13 < 8) ? 2'b01 : ((t % 13 < 11) ? 2'b10 : 2'b00);
         end
         g = (st == 2'b01) ? (2'b01 << ph) : 2'b00;
         y = (st == 2'b10) ? (2'b01 << ph) : 2'b00;
         r = (st == 2'b00) ? 2'b11 : ~(g | y);
         n_vec++;
         if ({if2.STATE, if2.PHASE, if2.GRN, if2.YLW, if2.RED} !== {st, ph, g, y, r}) begin
            n_bad++;
            $display("FAIL seq edge %0d: got st=%b ph=%b g=%b y=%b r=%b want st=%b ph=%b g=%b y=%b r=%b",
                     e, if2.STATE, if2.PHASE, if2.GRN, if2.YLW, if2.RED, st, ph, g, y, r);
         end
      end
   endtask

   task automatic test_prescale();
      int cyc = 0;
      int len = 0;
      if2.TEST = 1'b0; if2.REQ = 2'b11; if2.FM = 1'b0;
      start();
      while (if2.GRN[0] !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_vec++;
      if (cyc != 8) begin
         n_bad++;
         $display("FAIL prescale_first_green: got %0d edges want 8", cyc);
      end
      while (if2.GRN[0] === 1'b1 && len < 100) begin
         @(negedge clk);
         len++;
      end
      n_vec++;
      if (len != 32) begin
         n_bad++;
         $display("FAIL prescale_green_len: got %0d cycles want 32", len);
      end
   endtask

   task automatic test_hold_wrap();
      if4.TEST = 1'b1; if4.REQ = 4'b0100; if4.FM = 1'b0;
      start();
      repeat (2) @(negedge clk);
      n_vec++;
      if ({if4.STATE, if4.PHASE, if4.GRN, if4.RED} !== {2'b01, 2'd2, 4'b0100, 4'b1011}) begin
         n_bad++;
         $display("FAIL serve_dir2: got st=%b ph=%0d g=%b r=%b want st=01 ph=2 g=0100 r=1011",
                  if4.STATE, if4.PHASE, if4.GRN, if4.RED);
      end
      repeat (20) @(negedge clk);
      n_vec++;
      if ({if4.STATE, if4.GRN} !== {2'b01, 4'b0100}) begin
         n_bad++;
         $display("FAIL hold_green: got st=%b g=%b want st=01 g=0100", if4.STATE, if4.GRN);
      end
      if4.REQ = 4'b0101;
      @(negedge clk);
      n_vec++;
      if ({if4.STATE, if4.GRN, if4.YLW, if4.RED} !== {2'b10, 4'b0000, 4'b0100, 4'b1011}) begin
         n_bad++;
         $display("FAIL yellow_dir2: got st=%b g=%b y=%b r=%b want st=10 g=0000 y=0100 r=1011",
                  if4.STATE, if4.GRN, if4.YLW, if4.RED);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if ({if4.STATE, if4.RED} !== {2'b00, 4'b1111}) begin
         n_bad++;
         $display("FAIL ared_after_y: got st=%b r=%b want st=00 r=1111", if4.STATE, if4.RED);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if ({if4.STATE, if4.PHASE, if4.GRN} !== {2'b01, 2'd0, 4'b0001}) begin
         n_bad++;
         $display("FAIL wrap_to_dir0: got st=%b ph=%0d g=%b want st=01 ph=0 g=0001",
                  if4.STATE, if4.PHASE, if4.GRN);
      end
      if4.REQ = 4'b0000;
   endtask

   task automatic test_flash();
      logic [1:0] yexp;
      if2.TEST = 1'b1; if2.REQ = 2'b11; if2.FM = 1'b0;
      start();
      repeat (4) @(negedge clk);
      if2.FM = 1'b1;
      repeat (5) @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.GRN} !== {2'b01, 2'b01}) begin
         n_bad++;
         $display("FAIL min_green_kept: got st=%b g=%b want st=01 g=01", if2.STATE, if2.GRN);
      end
      @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.YLW} !== {2'b10, 2'b01}) begin
         n_bad++;
         $display("FAIL fm_yellow: got st=%b y=%b want st=10 y=01", if2.STATE, if2.YLW);
      end
      repeat (4) @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.RED} !== {2'b00, 2'b11}) begin
         n_bad++;
         $display("FAIL fm_ared: got st=%b r=%b want st=00 r=11", if2.STATE, if2.RED);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         yexp = (i % 2 == 0) ? 2'b11 : 2'b00;
         n_vec++;
         if ({if2.STATE, if2.GRN, if2.YLW, if2.RED} !== {2'b11, 2'b00, yexp, 2'b00}) begin
            n_bad++;
            $display("FAIL flash %0d: got st=%b g=%b y=%b r=%b want st=11 g=00 y=%b r=00",
                     i, if2.STATE, if2.GRN, if2.YLW, if2.RED, yexp);
         end
      end
      if2.FM = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.PHASE, if2.RED} !== {2'b00, 1'b0, 2'b11}) begin
         n_bad++;
         $display("FAIL flash_exit: got st=%b ph=%b r=%b want st=00 ph=0 r=11",
                  if2.STATE, if2.PHASE, if2.RED);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.PHASE, if2.GRN} !== {2'b01, 1'b1, 2'b10}) begin
         n_bad++;
         $display("FAIL after_flash_rr: got st=%b ph=%b g=%b want st=01 ph=1 g=10",
                  if2.STATE, if2.PHASE, if2.GRN);
      end
   endtask

   task automatic test_reset_mid();
      if2.TEST = 1'b1; if2.REQ = 2'b11; if2.FM = 1'b0;
      start();
      repeat (11) @(negedge clk);
      n_vec++;
      if (if2.STATE !== 2'b10) begin
         n_bad++;
         $display("FAIL pre_reset_yellow: got st=%b want 10", if2.STATE);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({if2.STATE, if2.PHASE, if2.GRN, if2.YLW, if2.RED} !== {2'b00, 1'b1, 2'b00, 2'b00, 2'b11}) begin
         n_bad++;
         $display("FAIL async_reset: got st=%b ph=%b g=%b y=%b r=%b want st=00 ph=1 g=00 y=00 r=11",
                  if2.STATE, if2.PHASE, if2.GRN, if2.YLW, if2.RED);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (if2.STATE !== 2'b00) begin
         n_bad++;
         $display("FAIL restart_ared: got st=%b want 00", if2.STATE);
      end
      @(negedge clk);
      n_vec++;
      if ({if2.STATE, if2.PHASE, if2.GRN} !== {2'b01, 1'b0, 2'b01}) begin
         n_bad++;
         $display("FAIL restart_green: got st=%b ph=%b g=%b want st=01 ph=0 g=01",
                  if2.STATE, if2.PHASE, if2.GRN);
      end
   endtask

   // Random stimulus on 3 directions: lamp safety every cycle, bounded wait on each green entry.
   task automatic test_random();
      int         starve [3];
      logic [1:0] prev_st;
      logic [2:0] act;
      logic       entry;
      if3.TEST = 1'b0; if3.REQ = 3'b000; if3.FM = 1'b0;
      for (int d = 0; d < 3; d++) starve[d] = 0;
      start();
      prev_st = 2'b00;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         act = if3.GRN | if3.YLW;
         n_vec++;
         if (if3.STATE == 2'b11) begin
            if ((if3.GRN | if3.RED) !== 3'b000) begin
               n_bad++;
               $display("FAIL flash_lamps cyc %0d: got g=%b r=%b want 000", c, if3.GRN, if3.RED);
            end
         end else if ($countones(act) > 1 || (act & if3.RED) != 3'b000) begin
            n_bad++;
            $display("FAIL safety cyc %0d: got g=%b y=%b r=%b want one-hot active, red off",
                     c, if3.GRN, if3.YLW, if3.RED);
         end
         entry = (if3.STATE == 2'b01) && (prev_st != 2'b01);
         for (int d = 0; d < 3; d++) begin
            if (!if3.REQ[d]) starve[d] = 0;
            else if (entry) begin
               if (int'(if3.PHASE) == d) starve[d] = 0;
               else starve[d]++;
               n_vec++;
               if (starve[d] > 2) begin
                  n_bad++;
                  $display("FAIL starve dir %0d cyc %0d: got %0d other greens want <= 2", d, c, starve[d]);
               end
            end
         end
         prev_st = if3.STATE;
         if ($urandom_range(7) == 0) if3.REQ = 3'($urandom);
         if (!if3.FM && $urandom_range(499) == 0) if3.FM = 1'b1;
         else if (if3.FM && $urandom_range(49) == 0) if3.FM = 1'b0;
         if ($urandom_range(99) == 0) if3.TEST = ~if3.TEST;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      if2.FM = 1'b0; if2.TEST = 1'b0; if2.REQ = '0;
      if4.FM = 1'b0; if4.TEST = 1'b0; if4.REQ = '0;
      if3.FM = 1'b0; if3.TEST = 1'b0; if3.REQ = '0;
      test_reset();
      test_test_mode();
      test_prescale();
      test_hold_wrap();
      test_flash();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
